// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: permutes the identity S memory using the secret key.
// Optional build macro KSA_SKIP_SELF_SWAP_EN skips iterations whose new j equals i.
module ksa_swap_fsm #(
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdI,
        StWtI,
        StCalc,
        StRdJ,
        StWtJ,
        StWrI,
        StWrJ,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    si_q, si_d;

    logic [7:0]    key_byte;
    logic [7:0]    j_new;
    logic [KW-1:0] k_next;

    // Byte 0 of the key sits in the most significant position.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k_q == KW'(b)) begin
                key_byte = secret_key[8*(KEY_BYTES-b)-1 -: 8];
            end
        end
    end

    assign j_new  = j_q + q + key_byte;
    assign k_next = (k_q == KW'(KEY_BYTES - 1)) ? '0 : k_q + KW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        address = '0;
        data    = '0;
        wren    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                busy = 1'b0;
                done = (state_q == StDone);
                if (start) begin
                    state_d = StRdI;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            StRdI: begin
                address = i_q;
                state_d = StWtI;
            end
            StWtI: begin
                address = i_q;
                state_d = StCalc;
            end
            StCalc: begin
                si_d    = q;
                j_d     = j_new;
                state_d = StRdJ;
`ifdef KSA_SKIP_SELF_SWAP_EN
                // A self-swap leaves memory unchanged, so advance straight to the next i.
                if (j_new == i_q) begin
                    i_d     = i_q + 8'd1;
                    k_d     = k_next;
                    state_d = (i_q == 8'd255) ? StDone : StRdI;
                end
`endif
            end
            StRdJ: begin
                address = j_q;
                state_d = StWtJ;
            end
            StWtJ: begin
                address = j_q;
                state_d = StWrI;
            end
            StWrI: begin
                address = i_q;
                data    = q;
                wren    = 1'b1;
                state_d = StWrJ;
            end
            StWrJ: begin
                address = j_q;
                data    = si_q;
                wren    = 1'b1;
                i_d     = i_q + 8'd1;
                k_d     = k_next;
                state_d = (i_q == 8'd255) ? StDone : StRdI;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Scoreboard bench for ksa_swap_fsm: a RAM model with two-cycle read latency,
// a software RC4 KSA model feeding an expected-write queue, and a write monitor.
module tb_ksa_swap_fsm;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [23:0] key0;
    logic [7:0]  key1;
    logic [7:0] q0, addr0, data0, q1, addr1, data1;
    logic       wren0, busy0, done0, wren1, busy1, done1;

    always #5 clk = ~clk;

    ksa_swap_fsm #(.KEY_BYTES(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .secret_key(key0), .q(q0),
        .address(addr0), .data(data0), .wren(wren0), .busy(busy0), .done(done0)
    );

    ksa_swap_fsm #(.KEY_BYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .secret_key(key1), .q(q1),
        .address(addr1), .data(data1), .wren(wren1), .busy(busy1), .done(done1)
    );

    // RAM models: registered address plus registered output.
    logic [7:0] mem0[256];
    logic [7:0] mem1[256];
    logic [7:0] aq0, aq1;
    logic       init0, init1;

    always @(posedge clk) begin
        aq0 <= addr0;
        q0  <= mem0[aq0];
        if (init0) begin
            for (int n = 0; n < 256; n++) mem0[n] <= 8'(n);
        end else if (wren0) begin
            mem0[addr0] <= data0;
        end
    end

    always @(posedge clk) begin
        aq1 <= addr1;
        q1  <= mem1[aq1];
        if (init1) begin
            for (int n = 0; n < 256; n++) mem1[n] <= 8'(n);
        end else if (wren1) begin
            mem1[addr1] <= data1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    wr_t        wq[$];
    wr_t        mon_e;
    logic       sel;
    logic       cap_en;
    logic [7:0] cap_a[8];
    logic [7:0] cap_d[8];
    int         cap_n;
    logic [7:0] exp_s[256];

    logic       mw;
    logic [7:0] ma, md;
    assign mw = sel ? wren1 : wren0;
    assign ma = sel ? addr1 : addr0;
    assign md = sel ? data1 : data0;

    always @(negedge clk) begin
        if (rst_n && mw) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", ma, md);
            end else begin
                mon_e = wq.pop_front();
                if (mon_e.a !== ma || mon_e.d !== md) begin
                    errors++;
                    $display("FAIL write: got (%0d,%0d) expected (%0d,%0d)",
                             ma, md, mon_e.a, mon_e.d);
                end
            end
            if (cap_en && cap_n < 8) begin
                cap_a[cap_n] = ma;
                cap_d[cap_n] = md;
                cap_n++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Software RC4 KSA on exp_s; queues the expected writes and returns the busy cycle count.
    task automatic model(input logic [7:0] kb[8], input int nk, output int cyc);
        logic [7:0] j;
        logic [7:0] t;
        cyc = 0;
        j   = 8'd0;
        wq.delete();
        for (int i = 0; i < 256; i++) begin
            j = j + exp_s[i] + kb[i % nk];
`ifdef KSA_SKIP_SELF_SWAP_EN
            if (j == 8'(i)) begin
                cyc += 3;
                continue;
            end
`endif
            wq.push_back({8'(i), exp_s[j]});
            wq.push_back({j, exp_s[i]});
            t        = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
            cyc += 7;
        end
    endtask

    task automatic run(input bit which, input int pulse_at, input int exp_cyc,
                       output int first_wren);
        int cnt;
        cnt        = 0;
        first_wren = -1;
        sel        = which;
        @(posedge clk); #1;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        while ((which ? busy1 : busy0) && cnt < 4000) begin
            cnt++;
            if ((which ? wren1 : wren0) && first_wren < 0) first_wren = cnt;
            if (which) start1 = (cnt == pulse_at); else start0 = (cnt == pulse_at);
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        start1 = 1'b0;
        chk("busy_cycles", cnt, exp_cyc);
        chk("done_after", which ? done1 : done0, 1);
        chk("busy_after", which ? busy1 : busy0, 0);
        chk("wren_after", which ? wren1 : wren0, 0);
        chk("queue_drained", wq.size(), 0);
    endtask

    task automatic mem_chk(input bit which, input string tag);
        for (int n = 0; n < 256; n++) begin
            chk($sformatf("%s_mem[%0d]", tag, n), which ? mem1[n] : mem0[n], exp_s[n]);
        end
    endtask

    task automatic init_mem(input bit which);
        @(posedge clk); #1;
        if (which) init1 = 1'b1; else init0 = 1'b1;
        @(posedge clk); #1;
        init0 = 1'b0;
        init1 = 1'b0;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
    endtask

    initial begin
        logic [7:0] kb[8];
        int cyc;
        int fw;
        int lim;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        init0  = 1'b1;
        init1  = 1'b1;
        key0   = 24'h000000;
        key1   = 8'h01;
        sel    = 1'b0;
        cap_en = 1'b0;
        cap_n  = 0;
        repeat (3) @(posedge clk);
        #1;
        init0 = 1'b0;
        init1 = 1'b0;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        chk("rst_address", addr0, 0);
        chk("rst_data", data0, 0);
        chk("rst_wren", wren0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", busy0, 0);

        // Key 0 on identity S
        kb = '{default: 8'h00};
        model(kb, 3, cyc);
        cap_en = 1'b1;
        cap_n  = 0;
`ifdef KSA_SKIP_SELF_SWAP_EN
        run(1'b0, 0, cyc, fw);
        cap_en = 1'b0;
        chk("k0_first_wren_cycle", fw, 12);
        chk("k0_w0_addr", cap_a[0], 2);
        chk("k0_w0_data", cap_d[0], 3);
        chk("k0_w1_addr", cap_a[1], 3);
        chk("k0_w1_data", cap_d[1], 2);
`else
        run(1'b0, 0, 1792, fw);
        cap_en = 1'b0;
        chk("k0_first_wren_cycle", fw, 6);
        chk("k0_w0", {cap_a[0], cap_d[0]}, 16'h0000);
        chk("k0_w1", {cap_a[1], cap_d[1]}, 16'h0000);
        chk("k0_w2", {cap_a[2], cap_d[2]}, 16'h0101);
        chk("k0_w3", {cap_a[3], cap_d[3]}, 16'h0101);
        chk("k0_w4", {cap_a[4], cap_d[4]}, 16'h0203);
        chk("k0_w5", {cap_a[5], cap_d[5]}, 16'h0302);
`endif
        mem_chk(1'b0, "k0");

        // Key 000249, start pulsed mid-run at the first cycle of iteration 100
        init_mem(1'b0);
        key0 = 24'h000249;
        kb = '{default: 8'h00};
        kb[1] = 8'h02;
        kb[2] = 8'h49;
        model(kb, 3, cyc);
        run(1'b0, 701, cyc, fw);
        mem_chk(1'b0, "k249");

        // Rerun after done on the already permuted memory
        model(kb, 3, cyc);
        cap_en = 1'b1;
        cap_n  = 0;
        run(1'b0, 0, cyc, fw);
        cap_en = 1'b0;
        mem_chk(1'b0, "rerun");

        // Asynchronous reset during the first WR_I cycle
        init_mem(1'b0);
        key0 = 24'h000000;
        kb = '{default: 8'h00};
        model(kb, 3, cyc);
        sel = 1'b0;
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        lim = 0;
        while (!wren0 && lim < 100) begin
            lim++;
            @(posedge clk); #1;
        end
        chk("reached_wr_i", wren0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wren", wren0, 0);
        chk("arst_address", addr0, 0);
        chk("arst_data", data0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_done", done0, 0);
        wq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", busy0, 0);
        chk("post_rst_done", done0, 0);
        chk("post_rst_wren", wren0, 0);

        // KEY_BYTES=1, key 01
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        kb = '{default: 8'h00};
        kb[0] = 8'h01;
        model(kb, 1, cyc);
        cap_en = 1'b1;
        cap_n  = 0;
        run(1'b1, 0, cyc, fw);
        cap_en = 1'b0;
        chk("kb1_w0", {cap_a[0], cap_d[0]}, 16'h0001);
        chk("kb1_w1", {cap_a[1], cap_d[1]}, 16'h0100);
        mem_chk(1'b1, "kb1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
